// File: rtl/e_mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : e_mult_div_unit_if
//  Description : E-stage operand/control bundle into the multiply/divide unit
//                and the HI/LO/busy/result bundle coming back out of it.
//  Revision    : 1.0  initial release
// ============================================================================
interface e_mult_div_unit_if;
    logic [31:0] E_rsValue_i;
    logic [31:0] E_rtValue_i;
    logic [3:0]  E_MDUop_i;
    logic        E_MDUstart_i;
    logic        E_MDUbusy_o;
    logic [31:0] E_HI_o;
    logic [31:0] E_LO_o;
    logic [31:0] E_MDUout_o;

    // Pipeline side: drives operands/op, observes status and results
    modport master (
        output E_rsValue_i, E_rtValue_i, E_MDUop_i, E_MDUstart_i,
        input  E_MDUbusy_o, E_HI_o, E_LO_o, E_MDUout_o
    );

    // Unit side
    modport slave (
        input  E_rsValue_i, E_rtValue_i, E_MDUop_i, E_MDUstart_i,
        output E_MDUbusy_o, E_HI_o, E_LO_o, E_MDUout_o
    );
endinterface
`default_nettype wire

// File: rtl/e_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : e_mult_div_unit
//  Description : Execute-stage multiply/divide unit owning HI/LO. The full
//                64-bit result is computed when the operation starts, held in
//                a pending register, and committed to HI/LO on the cycle busy
//                drops, so the latency is a pure counter.
//                Optional feature macro: MDU_MADD_EN (enables MADD/MADDU).
//  Revision    : 1.0  initial release
// ============================================================================
module e_mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic           clk,
    input  wire logic           reset,
    e_mult_div_unit_if.slave    mdu
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd9;
    localparam logic [3:0] c_OP_MADDU = 4'd10;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [63:0]          r_pending;
    logic                 r_commit;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;

    logic [31:0] w_rs;
    logic [31:0] w_rt;
    assign w_rs = mdu.E_rsValue_i;
    assign w_rt = mdu.E_rtValue_i;

    // Products: sign/zero-extend to 64 bits, the low 64 bits of the product
    // are exact for both interpretations.
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    assign w_prod_s = {{32{w_rs[31]}}, w_rs} * {{32{w_rt[31]}}, w_rt};
    assign w_prod_u = {32'd0, w_rs} * {32'd0, w_rt};

    // Division. A zero divisor is replaced by 1 so the arithmetic never sees
    // a zero denominator; the result is discarded anyway (r_commit = 0).
    logic        w_div_zero;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_den_s;
    logic [31:0] w_den_u;
    logic [31:0] w_quo_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;

    assign w_div_zero = (w_rt == 32'd0);
    assign w_rs_mag   = w_rs[31] ? (32'd0 - w_rs) : w_rs;
    assign w_rt_mag   = w_rt[31] ? (32'd0 - w_rt) : w_rt;
    assign w_den_s    = w_div_zero ? 32'd1 : w_rt_mag;
    assign w_den_u    = w_div_zero ? 32'd1 : w_rt;
    assign w_quo_mag  = w_rs_mag / w_den_s;
    assign w_rem_mag  = w_rs_mag % w_den_s;
    // Quotient truncates toward zero; remainder takes the dividend's sign
    assign w_quo_s    = (w_rs[31] ^ w_rt[31]) ? (32'd0 - w_quo_mag) : w_quo_mag;
    assign w_rem_s    = w_rs[31] ? (32'd0 - w_rem_mag) : w_rem_mag;
    assign w_quo_u    = w_rs / w_den_u;
    assign w_rem_u    = w_rs % w_den_u;

`ifdef MDU_MADD_EN
    // Accumulate against HI/LO as they stand when the MADD starts
    logic [63:0] w_madd_s;
    logic [63:0] w_madd_u;
    assign w_madd_s = {r_hi, r_lo} + w_prod_s;
    assign w_madd_u = {r_hi, r_lo} + w_prod_u;
`endif

    // Control FSM: accept ops when idle, count down latency, commit on last cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= c_CNT_ZERO;
            r_pending <= 64'd0;
            r_commit  <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mdu.E_MDUstart_i) begin
                        case (mdu.E_MDUop_i)
                            c_OP_MULT: begin
                                r_pending <= w_prod_s;
                                r_commit  <= 1'b1;
                                r_cnt     <= c_MULT_LOAD;
                                r_state   <= S_BUSY;
                            end
                            c_OP_MULTU: begin
                                r_pending <= w_prod_u;
                                r_commit  <= 1'b1;
                                r_cnt     <= c_MULT_LOAD;
                                r_state   <= S_BUSY;
                            end
                            c_OP_DIV: begin
                                r_pending <= {w_rem_s, w_quo_s};
                                r_commit  <= ~w_div_zero;
                                r_cnt     <= c_DIV_LOAD;
                                r_state   <= S_BUSY;
                            end
                            c_OP_DIVU: begin
                                r_pending <= {w_rem_u, w_quo_u};
                                r_commit  <= ~w_div_zero;
                                r_cnt     <= c_DIV_LOAD;
                                r_state   <= S_BUSY;
                            end
`ifdef MDU_MADD_EN
                            c_OP_MADD: begin
                                r_pending <= w_madd_s;
                                r_commit  <= 1'b1;
                                r_cnt     <= c_MULT_LOAD;
                                r_state   <= S_BUSY;
                            end
                            c_OP_MADDU: begin
                                r_pending <= w_madd_u;
                                r_commit  <= 1'b1;
                                r_cnt     <= c_MULT_LOAD;
                                r_state   <= S_BUSY;
                            end
`endif
                            c_OP_MTHI: r_hi <= w_rs;
                            c_OP_MTLO: r_lo <= w_rs;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    // Any new start while busy is ignored here by construction
                    if (r_cnt == c_CNT_ONE) begin
                        if (r_commit) begin
                            r_hi <= r_pending[63:32];
                            r_lo <= r_pending[31:0];
                        end
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= c_CNT_ZERO;
                end
            endcase
        end
    end

    // Move-from result path back to the E-stage write-back mux
    logic [31:0] w_out;
    always_comb begin
        w_out = 32'd0;
        case (mdu.E_MDUop_i)
            c_OP_MFHI: w_out = r_hi;
            c_OP_MFLO: w_out = r_lo;
            default:   w_out = 32'd0;
        endcase
    end

    assign mdu.E_MDUbusy_o = (r_state == S_BUSY);
    assign mdu.E_HI_o      = r_hi;
    assign mdu.E_LO_o      = r_lo;
    assign mdu.E_MDUout_o  = w_out;

endmodule
`default_nettype wire
